calc_operand_stack: RTL and testbench

- Parametrised operand store for the calculator datapath: digit-entry register plus a DEPTH-deep operand stack, replacing the fixed two-register (current/previous) scheme.
- Accepts keypad events, builds a sign-magnitude entry value of NDIG hex digits, and pushes it on operator keys.
- Pops the stack and loads the ALU answer on equals, so chained and nested operations keep earlier operands.
- Sits between the keypad decoder and the ALU/display.

---
 rtl/calc_operand_stack.sv | 161 ++++++++++++++++
 tb/tb_calc_operand_stack.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/calc_operand_stack.sv
// Calculator operand store: hex digit-entry register plus a DEPTH-deep operand stack.
// Optional recall key (rcl) is compiled in when CALC_RECALL_EN is defined.
module calc_operand_stack #(
  parameter  int NDIG  = 4,
  parameter  int DEPTH = 4,
  localparam int W     = 4*NDIG+1,
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          newhex,
  input  logic [3:0]    hexcode,
  input  logic          newop,
  input  logic          eq,
  input  logic          bs,
  input  logic          ce,
  input  logic          neg,
`ifdef CALC_RECALL_EN
  input  logic          rcl,
`endif
  input  logic [W-1:0]  answer,
  output logic [W-1:0]  entry,
  output logic [W-1:0]  top,
  output logic [CW-1:0] depth,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          err
);

  localparam int DW = $clog2(NDIG+1);

  logic [W-1:0]  entry_q, entry_d;
  logic [W-1:0]  top_q, top_d;
  logic [W-1:0]  stack_q [DEPTH];
  logic [W-1:0]  stack_d [DEPTH];
  logic [CW-1:0] depth_q, depth_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          flow_q, flow_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;

  logic [W-2:0]  mag, mag_bs, ans_mag;
  logic          sgn;

  // Position of the highest non-zero nibble = number of significant digits.
  function automatic logic [DW-1:0] sig_digits(input logic [W-2:0] m);
    logic [DW-1:0] n;
    n = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (m[4*i +: 4] != 4'h0) n = DW'(i + 1);
    end
    return n;
  endfunction

  always_comb begin
    entry_d = entry_q;
    depth_d = depth_q;
    dcnt_d  = dcnt_q;
    flow_d  = flow_q;
    ovf_d   = ovf_q;
    err_d   = 1'b0;
    for (int i = 0; i < DEPTH; i++) stack_d[i] = stack_q[i];

    mag     = entry_q[W-2:0];
    sgn     = entry_q[W-1];
    mag_bs  = mag >> 4;
    ans_mag = answer[W-2:0];

    if (ce) begin
      entry_d = '0;
      dcnt_d  = '0;
      ovf_d   = 1'b0;
      flow_d  = 1'b0;
    end else if (eq) begin
      entry_d = {(ans_mag != '0) & answer[W-1], ans_mag};
      dcnt_d  = sig_digits(ans_mag);
      flow_d  = 1'b1;
      ovf_d   = 1'b0;
      if (depth_q != '0) depth_d = depth_q - 1'b1;
      else               err_d   = 1'b1;
    end else if (newop) begin
      if (depth_q == CW'(DEPTH)) begin
        err_d = 1'b1;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i == int'(depth_q)) stack_d[i] = entry_q;
        end
        depth_d = depth_q + 1'b1;
        flow_d  = 1'b1;
        ovf_d   = 1'b0;
      end
`ifdef CALC_RECALL_EN
    end else if (rcl) begin
      if (depth_q != '0) begin
        entry_d = top_q;
        dcnt_d  = sig_digits(top_q[W-2:0]);
        flow_d  = 1'b1;
        ovf_d   = 1'b0;
      end else begin
        err_d = 1'b1;
      end
`endif
    end else if (bs) begin
      entry_d = {(mag_bs != '0) & sgn, mag_bs};
      dcnt_d  = (dcnt_q == '0) ? '0 : dcnt_q - 1'b1;
      ovf_d   = 1'b0;
    end else if (neg) begin
      if (mag != '0) entry_d = {~sgn, mag};
    end else if (newhex) begin
      if (flow_q) begin
        entry_d = {1'b0, (W-1)'(hexcode)};
        dcnt_d  = DW'(hexcode != 4'h0);
        ovf_d   = 1'b0;
        flow_d  = 1'b0;
      end else if (dcnt_q == DW'(NDIG)) begin
        ovf_d = 1'b1;
      end else begin
        entry_d = {sgn, mag[W-6:0], hexcode};
        if (!(mag == '0 && hexcode == 4'h0)) dcnt_d = dcnt_q + 1'b1;
      end
    end

    // Top is re-derived from the next-state stack so it tracks depth in the same cycle.
    top_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(depth_d) == i + 1) top_d = stack_d[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      entry_q <= '0;
      top_q   <= '0;
      depth_q <= '0;
      dcnt_q  <= '0;
      flow_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      entry_q <= entry_d;
      top_q   <= top_d;
      depth_q <= depth_d;
      dcnt_q  <= dcnt_d;
      flow_q  <= flow_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
    end
  end

  assign entry = entry_q;
  assign top   = top_q;
  assign depth = depth_q;
  assign full  = (depth_q == CW'(DEPTH));
  assign empty = (depth_q == '0);
  assign ovf   = ovf_q;
  assign err   = err_q;

endmodule

// File: tb/tb_calc_operand_stack.sv
// Directed bench for calc_operand_stack (NDIG=4, DEPTH=4); expectations queued at drive time.
module tb_calc_operand_stack;

  localparam int W  = 17;
  localparam int CW = 3;

  localparam logic [7:0] RST = 8'h80, CE = 8'h40, EQ = 8'h20, OP = 8'h10;
  localparam logic [7:0] RCL = 8'h08, BS = 8'h04, NEG = 8'h02, HEX = 8'h01, IDLE = 8'h00;

  logic          clock;
  logic          reset, newhex, newop, eq, bs, ce, neg;
  logic [3:0]    hexcode;
  logic [W-1:0]  answer;
  logic [W-1:0]  entry, top;
  logic [CW-1:0] depth;
  logic          full, empty, ovf, err;
`ifdef CALC_RECALL_EN
  logic          rcl;
`endif

  typedef struct {
    logic [W-1:0] entry;
    int           depth;
    logic [W-1:0] top;
    logic         ovf;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  calc_operand_stack #(.NDIG(4), .DEPTH(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .newhex  (newhex),
    .hexcode (hexcode),
    .newop   (newop),
    .eq      (eq),
    .bs      (bs),
    .ce      (ce),
    .neg     (neg),
`ifdef CALC_RECALL_EN
    .rcl     (rcl),
`endif
    .answer  (answer),
    .entry   (entry),
    .top     (top),
    .depth   (depth),
    .full    (full),
    .empty   (empty),
    .ovf     (ovf),
    .err     (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input string tag, input logic [7:0] m, input logic [3:0] hx,
                      input logic [W-1:0] ans, input logic [W-1:0] e_entry, input int e_depth,
                      input logic [W-1:0] e_top, input logic e_ovf, input logic e_err);
    exp_t e;
    @(negedge clock);
    reset   = m[7];
    ce      = m[6];
    eq      = m[5];
    newop   = m[4];
`ifdef CALC_RECALL_EN
    rcl     = m[3];
`endif
    bs      = m[2];
    neg     = m[1];
    newhex  = m[0];
    hexcode = hx;
    answer  = ans;
    e.entry = e_entry; e.depth = e_depth; e.top = e_top; e.ovf = e_ovf; e.err = e_err;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check({tag, ".entry"}, 32'(entry), 32'(e.entry));
    check({tag, ".depth"}, 32'(depth), 32'(e.depth));
    check({tag, ".top"},   32'(top),   32'(e.top));
    check({tag, ".full"},  32'(full),  32'(e.depth == 4));
    check({tag, ".empty"}, 32'(empty), 32'(e.depth == 0));
    check({tag, ".ovf"},   32'(ovf),   32'(e.ovf));
    check({tag, ".err"},   32'(err),   32'(e.err));
  endtask

  initial begin
    reset = 1'b0; newhex = 1'b0; newop = 1'b0; eq = 1'b0; bs = 1'b0; ce = 1'b0; neg = 1'b0;
    hexcode = 4'h0; answer = '0;
`ifdef CALC_RECALL_EN
    rcl = 1'b0;
`endif
    //   tag        mask      hx    answer     entry     dep top       ovf err
    step("rst",     RST,      4'h0, 17'h0,     17'h0,     0, 17'h0,    0, 0);
    // digit entry and overflow
    step("k1",      HEX,      4'h1, 17'h0,     17'h1,     0, 17'h0,    0, 0);
    step("k2",      HEX,      4'h2, 17'h0,     17'h12,    0, 17'h0,    0, 0);
    step("k3",      HEX,      4'h3, 17'h0,     17'h123,   0, 17'h0,    0, 0);
    step("k4",      HEX,      4'h4, 17'h0,     17'h1234,  0, 17'h0,    0, 0);
    step("k5ovf",   HEX,      4'h5, 17'h0,     17'h1234,  0, 17'h0,    1, 0);
    step("bs",      BS,       4'h0, 17'h0,     17'h0123,  0, 17'h0,    0, 0);
    // leading zeros do not consume digit slots
    step("ce0",     CE,       4'h0, 17'h0,     17'h0,     0, 17'h0,    0, 0);
    step("z0a",     HEX,      4'h0, 17'h0,     17'h0,     0, 17'h0,    0, 0);
    step("z0b",     HEX,      4'h0, 17'h0,     17'h0,     0, 17'h0,    0, 0);
    step("z7",      HEX,      4'h7, 17'h0,     17'h7,     0, 17'h0,    0, 0);
    step("z71",     HEX,      4'h1, 17'h0,     17'h71,    0, 17'h0,    0, 0);
    step("z712",    HEX,      4'h2, 17'h0,     17'h712,   0, 17'h0,    0, 0);
    step("z7123",   HEX,      4'h3, 17'h0,     17'h7123,  0, 17'h0,    0, 0);
    step("zovf",    HEX,      4'h4, 17'h0,     17'h7123,  0, 17'h0,    1, 0);
    // push, overwrite, equals
    step("ce1",     CE,       4'h0, 17'h0,     17'h0,     0, 17'h0,    0, 0);
    step("a1",      HEX,      4'h1, 17'h0,     17'h1,     0, 17'h0,    0, 0);
    step("a2",      HEX,      4'h2, 17'h0,     17'h12,    0, 17'h0,    0, 0);
    step("push12",  OP,       4'h0, 17'h0,     17'h12,    1, 17'h12,   0, 0);
    step("ovw5",    HEX,      4'h5, 17'h0,     17'h5,     1, 17'h12,   0, 0);
    step("eq17",    EQ,       4'h0, 17'h17,    17'h17,    0, 17'h0,    0, 0);
    // fill the stack, overflow push, drain it, underflow pop
    step("p1",      OP,       4'h0, 17'h0,     17'h17,    1, 17'h17,   0, 0);
    step("h2",      HEX,      4'h2, 17'h0,     17'h2,     1, 17'h17,   0, 0);
    step("p2",      OP,       4'h0, 17'h0,     17'h2,     2, 17'h2,    0, 0);
    step("h3",      HEX,      4'h3, 17'h0,     17'h3,     2, 17'h2,    0, 0);
    step("p3",      OP,       4'h0, 17'h0,     17'h3,     3, 17'h3,    0, 0);
    step("h4",      HEX,      4'h4, 17'h0,     17'h4,     3, 17'h3,    0, 0);
    step("p4full",  OP,       4'h0, 17'h0,     17'h4,     4, 17'h4,    0, 0);
    step("p5err",   OP,       4'h0, 17'h0,     17'h4,     4, 17'h4,    0, 1);
    step("errclr",  IDLE,     4'h0, 17'h0,     17'h4,     4, 17'h4,    0, 0);
    step("eqA",     EQ,       4'h0, 17'h9,     17'h9,     3, 17'h3,    0, 0);
    step("eqBnz",   EQ,       4'h0, 17'h10000, 17'h0,     2, 17'h2,    0, 0);
    step("eqC",     EQ,       4'h0, 17'h10020, 17'h10020, 1, 17'h17,   0, 0);
    step("eqD",     EQ,       4'h0, 17'h1,     17'h1,     0, 17'h0,    0, 0);
    step("eqUnd",   EQ,       4'h0, 17'h10005, 17'h10005, 0, 17'h0,    0, 1);
    step("errclr2", IDLE,     4'h0, 17'h0,     17'h10005, 0, 17'h0,    0, 0);
    // sign handling and clear-entry
    step("ce2",     CE,       4'h0, 17'h0,     17'h0,     0, 17'h0,    0, 0);
    step("neg0",    NEG,      4'h0, 17'h0,     17'h0,     0, 17'h0,    0, 0);
    step("k3b",     HEX,      4'h3, 17'h0,     17'h3,     0, 17'h0,    0, 0);
    step("neg3",    NEG,      4'h0, 17'h0,     17'h10003, 0, 17'h0,    0, 0);
    step("bsSign",  BS,       4'h0, 17'h0,     17'h0,     0, 17'h0,    0, 0);
    step("b1",      HEX,      4'h1, 17'h0,     17'h1,     0, 17'h0,    0, 0);
    step("bp1",     OP,       4'h0, 17'h0,     17'h1,     1, 17'h1,    0, 0);
    step("b2",      HEX,      4'h2, 17'h0,     17'h2,     1, 17'h1,    0, 0);
    step("bp2",     OP,       4'h0, 17'h0,     17'h2,     2, 17'h2,    0, 0);
    step("ceKeep",  CE,       4'h0, 17'h0,     17'h0,     2, 17'h2,    0, 0);
    // same-cycle priority
    step("eqOverOp", EQ|OP|HEX, 4'h9, 17'h33,  17'h33,    1, 17'h1,    0, 0);
    step("opOverBs", OP|BS|HEX, 4'h9, 17'h0,   17'h33,    2, 17'h33,   0, 0);
    step("bsOverNg", BS|NEG|HEX, 4'h9, 17'h0,  17'h3,     2, 17'h33,   0, 0);
    step("ngOverHx", NEG|HEX, 4'h9, 17'h0,     17'h10003, 2, 17'h33,   0, 0);
    step("ceOverEq", CE|EQ,   4'h0, 17'h55,    17'h0,     2, 17'h33,   0, 0);
    step("rstMid",   RST|OP|HEX, 4'h9, 17'h0,  17'h0,     0, 17'h0,    0, 0);
`ifdef CALC_RECALL_EN
    step("rA",      HEX,      4'hA, 17'h0,     17'hA,     0, 17'h0,    0, 0);
    step("rB",      HEX,      4'hB, 17'h0,     17'hAB,    0, 17'h0,    0, 0);
    step("rPush",   OP,       4'h0, 17'h0,     17'hAB,    1, 17'hAB,   0, 0);
    step("rK1",     HEX,      4'h1, 17'h0,     17'h1,     1, 17'hAB,   0, 0);
    step("rcl",     RCL|BS,   4'h0, 17'h0,     17'hAB,    1, 17'hAB,   0, 0);
    step("rOvw",    HEX,      4'h5, 17'h0,     17'h5,     1, 17'hAB,   0, 0);
    step("rPop",    EQ,       4'h0, 17'h0,     17'h0,     0, 17'h0,    0, 0);
    step("rclEmp",  RCL,      4'h0, 17'h0,     17'h0,     0, 17'h0,    0, 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
